// File: rtl/controle_exibicao_pkg.sv
// Shared definitions for the LED-display sequencer of the memory game:
// state codes (also the db_estado debug values) and default sizing.
package controle_exibicao_pkg;

  typedef enum logic [3:0] {
    ESPERA  = 4'd0,
    PREPARA = 4'd1,
    LIGA    = 4'd2,
    DESLIGA = 4'd3,
    FIM     = 4'd4
  } estado_t;

  localparam int unsigned T_ON_PADRAO   = 2000;
  localparam int unsigned T_OFF_PADRAO  = 1000;
  localparam int unsigned ADDR_W_PADRAO = 4;
  localparam int unsigned DATA_W_PADRAO = 4;

  // Counter width able to hold max(a,b)-1; never narrower than one bit.
  function automatic int unsigned largura_contador(input int unsigned a,
                                                   input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/controle_exibicao_contador.sv
// Shared on/off timer: counts while enabled, clears on request, and flags
// the cycle in which the count equals the selected terminal value.
module contador_tempo #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic               habilita,
  input  logic [LARGURA-1:0] terminal,
  output logic               fim_contagem
);

  logic [LARGURA-1:0] conta_q, conta_d;

  always_comb begin
    conta_d = conta_q;
    if (limpa) begin
      conta_d = '0;
    end else if (habilita) begin
      conta_d = conta_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign fim_contagem = habilita && (conta_q == terminal);

endmodule

// File: rtl/controle_exibicao.sv
// Display sequencer: walks memory addresses 0..limite, showing each pattern
// for T_ON cycles followed by a T_OFF dark gap, then pulses fim.
module controle_exibicao
  import controle_exibicao_pkg::*;
#(
  parameter int unsigned T_ON   = T_ON_PADRAO,
  parameter int unsigned T_OFF  = T_OFF_PADRAO,
  parameter int unsigned ADDR_W = ADDR_W_PADRAO,
  parameter int unsigned DATA_W = DATA_W_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  localparam int unsigned LARGURA = largura_contador(T_ON, T_OFF);

  estado_t            estado_q, estado_d;
  logic [ADDR_W-1:0]  endereco_q, endereco_d;
  logic [ADDR_W-1:0]  limite_q, limite_d;
  logic [DATA_W-1:0]  leds_q, leds_d;
  logic               fim_q, fim_d;

  logic               tempo_ativo;
  logic               tempo_limpa;
  logic               tempo_fim;
  logic [LARGURA-1:0] tempo_terminal;

  // One timer serves both timed states; the terminal value follows the state.
  assign tempo_ativo    = (estado_q == LIGA) || (estado_q == DESLIGA);
  assign tempo_limpa    = abortar || tempo_fim || !tempo_ativo;
  assign tempo_terminal = (estado_q == LIGA) ? LARGURA'(T_ON - 1)
                                             : LARGURA'(T_OFF - 1);

  contador_tempo #(
    .LARGURA (LARGURA)
  ) u_contador (
    .clock        (clock),
    .reset        (reset),
    .limpa        (tempo_limpa),
    .habilita     (tempo_ativo),
    .terminal     (tempo_terminal),
    .fim_contagem (tempo_fim)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    leds_d     = leds_q;
    fim_d      = 1'b0;

    if (abortar && (estado_q != ESPERA)) begin
      estado_d   = ESPERA;
      endereco_d = '0;
      leds_d     = '0;
    end else begin
      case (estado_q)
        ESPERA: begin
          endereco_d = '0;
          leds_d     = '0;
          if (iniciar && !abortar) begin
            limite_d = limite;
            estado_d = PREPARA;
          end
        end
        PREPARA: begin
          leds_d   = dado_memoria;
          estado_d = LIGA;
        end
        LIGA: begin
          if (tempo_fim) begin
            leds_d   = '0;
            estado_d = DESLIGA;
          end
        end
        DESLIGA: begin
          // Compare before incrementing so the last address never wraps.
          if (tempo_fim) begin
            if (endereco_q == limite_q) begin
              fim_d    = 1'b1;
              estado_d = FIM;
            end else begin
              endereco_d = endereco_q + ADDR_W'(1);
              estado_d   = PREPARA;
            end
          end
        end
        FIM: begin
          endereco_d = '0;
          leds_d     = '0;
          estado_d   = ESPERA;
        end
        default: begin
          endereco_d = '0;
          leds_d     = '0;
          estado_d   = ESPERA;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ESPERA;
      endereco_q <= '0;
      limite_q   <= '0;
      leds_q     <= '0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      leds_q     <= leds_d;
      fim_q      <= fim_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign fim       = fim_q;
  assign ocupado   = (estado_q != ESPERA);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_exibicao.sv
// Bench for controle_exibicao: two instances (T_ON=3/T_OFF=2 and 1/1) checked
// cycle by cycle against an arithmetic timeline model of the display sequence.
module tb_controle_exibicao;

  logic       clock = 1'b0;
  logic       reset;
  logic       abortar;
  logic       iniciar0, iniciar1;
  logic [3:0] limite;
  logic [3:0] end0, end1, leds0, leds1, dado0, dado1, db0, db1;
  logic       ocup0, ocup1, fim0, fim1;
  logic [3:0] mem [16];

  int n_checks = 0;
  int n_falhas = 0;

  always #5 clock = ~clock;

  assign dado0 = mem[end0];
  assign dado1 = mem[end1];

  controle_exibicao #(.T_ON(3), .T_OFF(2), .ADDR_W(4), .DATA_W(4)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar0), .abortar(abortar),
    .limite(limite), .dado_memoria(dado0), .endereco(end0), .leds(leds0),
    .ocupado(ocup0), .fim(fim0), .db_estado(db0)
  );

  controle_exibicao #(.T_ON(1), .T_OFF(1), .ADDR_W(4), .DATA_W(4)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .abortar(abortar),
    .limite(limite), .dado_memoria(dado1), .endereco(end1), .leds(leds1),
    .ocupado(ocup1), .fim(fim1), .db_estado(db1)
  );

  task automatic verifica(input string tag, input logic [31:0] obs,
                          input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  // Expected outputs t cycles after the accepting edge: each step is one
  // prepare cycle, t_on lit cycles, t_off dark cycles; fim after L+1 steps.
  task automatic confere(input int sel, input int t, input int lim,
                         input bit ocioso, input string ctx);
    int t_on, t_off, s, i, r;
    int e_end, e_leds, e_ocup, e_fim, e_db;
    t_on  = sel ? 1 : 3;
    t_off = sel ? 1 : 2;
    s     = 1 + t_on + t_off;
    if (ocioso || t > (lim + 1) * s) begin
      e_end = 0; e_leds = 0; e_ocup = 0; e_fim = 0; e_db = 0;
    end else if (t == (lim + 1) * s) begin
      e_end = lim; e_leds = 0; e_ocup = 1; e_fim = 1; e_db = 4;
    end else begin
      i      = t / s;
      r      = t % s;
      e_end  = i;
      e_leds = (r >= 1 && r <= t_on) ? int'(mem[i]) : 0;
      e_ocup = 1;
      e_fim  = 0;
      e_db   = (r == 0) ? 1 : ((r <= t_on) ? 2 : 3);
    end
    verifica($sformatf("%s t=%0d endereco", ctx, t), sel ? end1 : end0, e_end);
    verifica($sformatf("%s t=%0d leds", ctx, t), sel ? leds1 : leds0, e_leds);
    verifica($sformatf("%s t=%0d ocupado", ctx, t), sel ? ocup1 : ocup0, e_ocup);
    verifica($sformatf("%s t=%0d fim", ctx, t), sel ? fim1 : fim0, e_fim);
    verifica($sformatf("%s t=%0d db_estado", ctx, t), sel ? db1 : db0, e_db);
  endtask

  task automatic rodada(input int sel, input int lim, input int corta_em,
                        input bit corta_reset, input int reinicia_em,
                        input bit muda_limite, input string ctx);
    int s, total;
    bit cortado;
    cortado = 1'b0;
    s       = sel ? 3 : 6;
    total   = (lim + 1) * s + 2;
    @(negedge clock);
    limite = 4'(lim);
    if (sel != 0) iniciar1 = 1'b1; else iniciar0 = 1'b1;
    for (int t = 0; t <= total; t++) begin
      @(negedge clock);
      iniciar0 = 1'b0; iniciar1 = 1'b0; abortar = 1'b0; reset = 1'b0;
      confere(sel, t, lim, cortado, ctx);
      if (muda_limite) limite = 4'($urandom);
      if (t == reinicia_em) begin
        if (sel != 0) iniciar1 = 1'b1; else iniciar0 = 1'b1;
      end
      if (t == corta_em) begin
        if (corta_reset) reset = 1'b1; else abortar = 1'b1;
        cortado = 1'b1;
      end
    end
    iniciar0 = 1'b0; iniciar1 = 1'b0; abortar = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int sel, lim, s, corta, reinicia;
    bit usa_reset, muda;
    reset = 1'b1; abortar = 1'b0; iniciar0 = 1'b0; iniciar1 = 1'b0;
    limite = 4'd0;
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    for (int k = 4; k < 16; k++) mem[k] = 4'($urandom);
    repeat (3) @(negedge clock);
    confere(0, 0, 0, 1'b1, "reset");
    confere(1, 0, 0, 1'b1, "reset");
    reset = 1'b0;

    rodada(0, 2, 2, 1'b1, -1, 1'b0, "reset_liga");
    rodada(0, 2, -1, 1'b0, -1, 1'b0, "lim2");
    rodada(0, 0, -1, 1'b0, -1, 1'b0, "lim0");
    rodada(0, 2, 10, 1'b0, -1, 1'b0, "aborta_desliga");
    rodada(0, 2, -1, 1'b0, -1, 1'b0, "reinicio");
    rodada(0, 2, -1, 1'b0, 2, 1'b1, "ignora_reinicio");
    rodada(1, 15, -1, 1'b0, -1, 1'b0, "lim15");

    @(negedge clock);
    abortar = 1'b1; iniciar0 = 1'b1; iniciar1 = 1'b1; limite = 4'd3;
    @(negedge clock);
    abortar = 1'b0; iniciar0 = 1'b0; iniciar1 = 1'b0;
    confere(0, 0, 0, 1'b1, "aborta_espera");
    confere(1, 0, 0, 1'b1, "aborta_espera");
    @(negedge clock);
    confere(0, 0, 0, 1'b1, "aborta_espera2");

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 16; k++) mem[k] = 4'($urandom);
      sel       = int'($urandom_range(0, 1));
      lim       = (sel != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      s         = (sel != 0) ? 3 : 6;
      corta     = -1;
      reinicia  = -1;
      usa_reset = 1'($urandom);
      muda      = 1'($urandom);
      if ($urandom_range(0, 2) == 0) corta = int'($urandom_range(0, (lim + 1) * s));
      else if ($urandom_range(0, 1) == 0) reinicia = int'($urandom_range(0, (lim + 1) * s));
      rodada(sel, lim, corta, usa_reset, reinicia, muda, $sformatf("aleat%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
    $finish;
  end

endmodule
